// File: rtl/bresenham_line_pkg.sv
// Shared types for the Bresenham line walker: point type, framebuffer size, FSM states.
// Framebuffer size defaults come from `WIDTH / `HEIGHT; clipping is enabled by BRESEN_CLIP_EN.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

package bresenham_line_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } point2d_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } bresen_state_t;

    function automatic logic in_fb(input point2d_t pt, input int w, input int h);
        return (pt.x >= 16'sd0) && (int'(pt.x) < w)
            && (pt.y >= 16'sd0) && (int'(pt.y) < h);
    endfunction

endpackage

// File: rtl/bresenham_line_setup.sv
// Combinational line setup: deltas, step directions and initial error term.
// Optional clipping (BRESEN_CLIP_EN) lives in the top, not here.
module bresenham_line_setup
    import bresenham_line_pkg::*;
(
    input  point2d_t           p,
    input  point2d_t           q,
    output logic signed [16:0] dx,
    output logic signed [16:0] dy,
    output logic signed [1:0]  sx,
    output logic signed [1:0]  sy,
    output logic signed [17:0] err0
);

    logic signed [16:0] ddx;
    logic signed [16:0] ddy;

    always_comb begin
        ddx  = $signed({q.x[15], q.x}) - $signed({p.x[15], p.x});
        ddy  = $signed({q.y[15], q.y}) - $signed({p.y[15], p.y});
        dx   = ddx[16] ? -ddx : ddx;
        dy   = ddy[16] ? ddy : -ddy;
        sx   = ($signed(p.x) < $signed(q.x)) ? 2'sb01 : 2'sb11;
        sy   = ($signed(p.y) < $signed(q.y)) ? 2'sb01 : 2'sb11;
        err0 = $signed({dx[16], dx}) + $signed({dy[16], dy});
    end

endmodule

// File: rtl/bresenham_line.sv
// Bresenham line walker: one pixel per handshake from p to q inclusive, then a done pulse.
// Define BRESEN_CLIP_EN to suppress pixel_valid for off-framebuffer pixels.
module bresenham_line
    import bresenham_line_pkg::*;
#(
    parameter int FB_WIDTH  = `WIDTH,
    parameter int FB_HEIGHT = `HEIGHT
) (
    input  logic     clk,
    input  logic     n_rst,
    input  logic     start,
    input  point2d_t p,
    input  point2d_t q,
    output point2d_t pixel,
    output logic     pixel_valid,
    input  logic     pixel_ready,
    output logic     busy,
    output logic     done
);

    bresen_state_t      state;
    point2d_t           end_pt;
    logic signed [16:0] dx_r;
    logic signed [16:0] dy_r;
    logic signed [1:0]  sx_r;
    logic signed [1:0]  sy_r;
    logic signed [17:0] err_r;

    logic signed [16:0] dx0;
    logic signed [16:0] dy0;
    logic signed [1:0]  sx0;
    logic signed [1:0]  sy0;
    logic signed [17:0] err0;

    bresenham_line_setup u_setup (
        .p    (p),
        .q    (q),
        .dx   (dx0),
        .dy   (dy0),
        .sx   (sx0),
        .sy   (sy0),
        .err0 (err0)
    );

    function automatic logic visible(input point2d_t pt);
`ifdef BRESEN_CLIP_EN
        return in_fb(pt, FB_WIDTH, FB_HEIGHT);
`else
        return (pt == pt) || 1'b1;
`endif
    endfunction

    logic signed [18:0] e2;
    logic               step_x;
    logic               step_y;
    logic               advance;
    logic               at_end;
    point2d_t           nxt;
    logic signed [17:0] nerr;

    always_comb begin
        e2      = $signed({err_r, 1'b0});
        step_x  = e2 >= $signed({{2{dy_r[16]}}, dy_r});
        step_y  = e2 <= $signed({{2{dx_r[16]}}, dx_r});
        nxt     = pixel;
        nerr    = err_r;
        if (step_x) begin
            nxt.x = pixel.x + {{14{sx_r[1]}}, sx_r};
            nerr  = nerr + $signed({dy_r[16], dy_r});
        end
        if (step_y) begin
            nxt.y = pixel.y + {{14{sy_r[1]}}, sy_r};
            nerr  = nerr + $signed({dx_r[16], dx_r});
        end
        // Off-screen pixels carry valid=0 and step without waiting for ready
        advance = (state == ST_DRAW) && (pixel_ready || !pixel_valid);
        at_end  = (pixel == end_pt);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            end_pt      <= '0;
            dx_r        <= '0;
            dy_r        <= '0;
            sx_r        <= '0;
            sy_r        <= '0;
            err_r       <= '0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        end_pt      <= q;
                        dx_r        <= dx0;
                        dy_r        <= dy0;
                        sx_r        <= sx0;
                        sy_r        <= sy0;
                        err_r       <= err0;
                        pixel       <= p;
                        pixel_valid <= visible(p);
                        busy        <= 1'b1;
                        state       <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (advance) begin
                        if (at_end) begin
                            pixel_valid <= 1'b0;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            pixel       <= nxt;
                            err_r       <= nerr;
                            pixel_valid <= visible(nxt);
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    pixel_valid <= 1'b0;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
